mult_accum: RTL and testbench

- Downstream consumer of the 64-bit unsigned product `s` from the 32x32 right-shift multiplier `mult`.
- Accepts one product per cycle over a valid/ready handshake and sums COUNT consecutive products into a wide accumulator.
- Presents the finished sum, with a sticky overflow flag, on an output valid/ready handshake.
- Used for dot-product / multiply-accumulate batches built on `mult`.

---
 rtl/mult_accum.sv | 89 ++++++++
 tb/tb_mult_accum.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// Batch multiply-accumulate: sums COUNT unsigned products from `mult` and presents
// the wrapped sum plus a sticky overflow flag on a valid/ready output handshake.
module mult_accum #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 72,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic [CNT_W-1:0]  batch_cnt
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("mult_accum: ACC_W must be >= PROD_W");
  end
  if (COUNT < 1 || (64'd1 << CNT_W) <= 64'(COUNT)) begin : g_bad_count
    $error("mult_accum: COUNT must be >= 1 and fit in CNT_W bits");
  end

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ov_q;
  logic               out_valid_q;
  logic               accept;
  logic               last;
  logic [ACC_W:0]     sum;

  // in_ready depends only on state and reset, never on in_valid.
  assign in_ready = rst_n && (state_q == StAccum);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CNT_W'(COUNT - 1));
  // One extra bit captures the carry that sets the sticky overflow.
  assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s};

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            acc_q <= sum[ACC_W-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (sum[ACC_W]) ov_q <= 1'b1;
            if (last) begin
              state_q     <= StHold;
              out_valid_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            ov_q        <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StAccum;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign overflow  = ov_q;
  assign batch_cnt = cnt_q;

endmodule

// File: tb/tb_mult_accum.sv
// Bench for mult_accum: three configurations (72/4, 64/2, 72/1) checked every cycle against
// a batch-level model, plus directed vectors with literal expected values.
module tb_mult_accum;

  logic        clk;
  logic        rst_n;
  logic        iv[3];
  logic        clr[3];
  logic        ordy[3];
  logic [63:0] sv[3];
  logic        ir[3];
  logic        outv[3];
  logic        ov_o[3];
  logic [7:0]  bc[3];
  logic [71:0] acc0;
  logic [63:0] acc1;
  logic [71:0] acc2;

  int total = 0;
  int bad   = 0;

  mult_accum #(.PROD_W(64), .ACC_W(72), .COUNT(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .s(sv[0]), .out_valid(outv[0]), .out_ready(ordy[0]), .acc_out(acc0),
    .overflow(ov_o[0]), .batch_cnt(bc[0])
  );
  mult_accum #(.PROD_W(64), .ACC_W(64), .COUNT(2), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .s(sv[1]), .out_valid(outv[1]), .out_ready(ordy[1]), .acc_out(acc1),
    .overflow(ov_o[1]), .batch_cnt(bc[1])
  );
  mult_accum #(.PROD_W(64), .ACC_W(72), .COUNT(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .s(sv[2]), .out_valid(outv[2]), .out_ready(ordy[2]), .acc_out(acc2),
    .overflow(ov_o[2]), .batch_cnt(bc[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Batch-level model: per-instance sum, count, sticky flag and "result pending".
  int unsigned acc_w[3] = '{72, 64, 72};
  int unsigned count[3] = '{4, 2, 1};
  logic [127:0] m_acc[3];
  int           m_cnt[3];
  bit           m_ov[3];
  bit           m_hold[3];
  bit           model_ok = 1'b0;

  function automatic logic [127:0] wrap_mask(input int unsigned w);
    return (128'h1 << w) - 128'h1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || clr[i] || (m_hold[i] && ordy[i])) begin
        m_acc[i]  <= '0;
        m_cnt[i]  <= 0;
        m_ov[i]   <= 1'b0;
        m_hold[i] <= 1'b0;
      end else if (!m_hold[i] && iv[i]) begin
        m_acc[i] <= (m_acc[i] + {64'h0, sv[i]}) & wrap_mask(acc_w[i]);
        if (((m_acc[i] + {64'h0, sv[i]}) >> acc_w[i]) != 0) m_ov[i] <= 1'b1;
        m_cnt[i] <= m_cnt[i] + 1;
        if (m_cnt[i] + 1 == int'(count[i])) m_hold[i] <= 1'b1;
      end
    end
    if (!rst_n) model_ok <= 1'b1;
  end

  task automatic chk_inst(input int i, input logic [127:0] acc);
    chk($sformatf("i%0d_in_ready", i), ir[i], rst_n && !m_hold[i]);
    chk($sformatf("i%0d_out_valid", i), outv[i], m_hold[i]);
    chk($sformatf("i%0d_overflow", i), ov_o[i], m_ov[i]);
    chk($sformatf("i%0d_batch_cnt", i), bc[i], m_cnt[i]);
    chk($sformatf("i%0d_acc_out", i), acc, m_acc[i]);
  endtask

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      chk_inst(0, {56'h0, acc0});
      chk_inst(1, {64'h0, acc1});
      chk_inst(2, {56'h0, acc2});
    end
  end

  localparam logic [63:0]  Sq  = 64'hFFFF_FFFE_0000_0001;
  localparam logic [127:0] Sq4 = 128'h3_FFFF_FFF8_0000_0004;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; clr[i] = 1'b0; ordy[i] = 1'b0; sv[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", ir[0], 1'b0);
    chk("rst_out_valid", outv[0], 1'b0);
    chk("rst_batch_cnt", bc[0], 8'd0);
    chk("rst_overflow", ov_o[0], 1'b0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready_high", ir[0], 1'b1);

    // Basic batch 1,2,3,4.
    ordy[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      iv[0] = 1'b1; sv[0] = 64'(k);
      @(negedge clk);
      iv[0] = 1'b0;
      chk("basic_cnt", bc[0], 8'(k));
      if (k < 4) chk("basic_not_valid", outv[0], 1'b0);
    end
    chk("basic_out_valid", outv[0], 1'b1);
    chk("basic_acc", acc0, 72'd10);
    chk("basic_ov", ov_o[0], 1'b0);
    @(negedge clk);
    chk("basic_handoff_valid", outv[0], 1'b0);
    chk("basic_handoff_cnt", bc[0], 8'd0);

    // Backpressure with four 0xFFFFFFFF squares.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; sv[0] = Sq;
    repeat (4) @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_valid", outv[0], 1'b1);
    chk("bp_acc", acc0, Sq4);
    for (int k = 0; k < 5; k++) begin
      iv[0] = 1'b1; sv[0] = 64'd5;
      @(negedge clk);
      chk("bp_hold_valid", outv[0], 1'b1);
      chk("bp_hold_ready", ir[0], 1'b0);
      chk("bp_hold_acc", acc0, Sq4);
      chk("bp_hold_cnt", bc[0], 8'd4);
    end
    ordy[0] = 1'b1; sv[0] = 64'd9;
    @(negedge clk);
    chk("bp_release_valid", outv[0], 1'b0);
    chk("bp_release_cnt", bc[0], 8'd0);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_resume_cnt", bc[0], 8'd1);
    chk("bp_resume_acc", acc0, 72'd9);

    // Clear mid-batch drops a simultaneous product.
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    iv[0] = 1'b1; sv[0] = 64'd5;
    @(negedge clk);
    sv[0] = 64'd6;
    @(negedge clk);
    chk("clr_pre_acc", acc0, 72'd11);
    clr[0] = 1'b1; sv[0] = 64'd7;
    @(negedge clk);
    clr[0] = 1'b0;
    iv[0] = 1'b0;
    chk("clr_cnt", bc[0], 8'd0);
    chk("clr_acc", acc0, 72'd0);
    iv[0] = 1'b1; sv[0] = 64'd1;
    repeat (4) @(negedge clk);
    iv[0] = 1'b0;
    chk("clr_next_valid", outv[0], 1'b1);
    chk("clr_next_acc", acc0, 72'd4);
    @(negedge clk);

    // Synchronous reset while a result is held.
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sv[0] = 64'(k);
      @(negedge clk);
    end
    chk("srst_hold_acc", acc0, 72'd10);
    chk("srst_hold_valid", outv[0], 1'b1);
    sv[0] = 64'd3;
    rst_n = 1'b0;
    #1 chk("srst_in_ready", ir[0], 1'b0);
    @(negedge clk);
    chk("srst_valid", outv[0], 1'b0);
    chk("srst_cnt", bc[0], 8'd0);
    chk("srst_ov", ov_o[0], 1'b0);
    repeat (2) @(negedge clk);
    chk("srst_no_accept", bc[0], 8'd0);
    rst_n = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);

    // Overflow on the 64-bit, COUNT=2 instance, then a clean batch.
    ordy[1] = 1'b1;
    iv[1] = 1'b1; sv[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    sv[1] = 64'h2;
    @(negedge clk);
    iv[1] = 1'b0;
    chk("ovf_valid", outv[1], 1'b1);
    chk("ovf_acc", acc1, 64'd1);
    chk("ovf_flag", ov_o[1], 1'b1);
    @(negedge clk);
    chk("ovf_cleared", ov_o[1], 1'b0);
    iv[1] = 1'b1; sv[1] = 64'd3;
    @(negedge clk);
    sv[1] = 64'd4;
    @(negedge clk);
    iv[1] = 1'b0;
    chk("ovf_next_acc", acc1, 64'd7);
    chk("ovf_next_flag", ov_o[1], 1'b0);
    @(negedge clk);

    // Streaming, COUNT=1: odd-numbered inputs land, even ones hit the handoff cycle.
    ordy[2] = 1'b1;
    iv[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sv[2] = 64'(k);
      @(negedge clk);
      if (k % 2 == 1) begin
        chk("stream_valid", outv[2], 1'b1);
        chk("stream_acc", acc2, 72'(k));
      end else begin
        chk("stream_gap", outv[2], 1'b0);
      end
    end
    iv[2] = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
